// File: rtl/bus_initiator_pkg.sv
// bus_initiator_pkg: shared widths, FSM state type and FIFO request word for bus_initiator.
package bus_initiator_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;
endpackage

// File: rtl/bus_initiator_fifo.sv
// bus_initiator_fifo: synchronous FIFO of DEPTH elements of type T, async active-high reset.
// Ports: clk_i, rst_i; push_i/data_i write side (ignored when full);
//        pop_i/data_o read side (data_o shows the head, pop ignored when empty);
//        full_o, empty_o status.
module bus_initiator_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);

    T           mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= wr_q + 1'b1;
            if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/bus_initiator.sv
// bus_initiator: queues valid/ready requests and runs them one at a time on the cs/rw/addr/data bus.
// Parameters: DEPTH request FIFO entries (power of two, >=2); TIMEOUT_CYCLES ACCESS cycle limit.
// Optional macro BUS_INITIATOR_TIMEOUT_EN: aborts an ACCESS with rsp_err after TIMEOUT_CYCLES.
// Ports: clk, reset (async active-high);
//        req_valid/req_ready/req_rw/req_addr/req_wdata upstream request port;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err upstream response port;
//        cs/rw/addr/data_out driven to the responder, data_in/ready returned from it.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              cs,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready
);
    req_t   head;
    logic   full, empty, pop, tmo;
    state_e state_q, state_d;
    logic              cs_q, cs_d, rw_q, rw_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

    bus_initiator_fifo #(.DEPTH(DEPTH), .T(req_t)) u_fifo (
        .clk_i  (clk),
        .rst_i  (reset),
        .push_i (req_valid),
        .data_i ('{rw: req_rw, addr: req_addr, wdata: req_wdata}),
        .pop_i  (pop),
        .data_o (head),
        .full_o (full),
        .empty_o(empty)
    );

`ifdef BUS_INITIATOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    // Counts ACCESS cycles; zero outside ACCESS so every access starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
    end
    assign tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
    // Watchdog compiled out: a negative limit can never be configured, so this never fires.
    assign tmo = TIMEOUT_CYCLES < 0;
`endif

    assign req_ready = !full;
    assign rsp_valid = state_q == RESP;
    assign cs        = cs_q;
    assign rw        = rw_q;
    assign addr      = addr_q;
    assign data_out  = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop = 1'b1;
                if (head.addr[1:0] == 2'b00) begin
                    cs_d    = 1'b1;
                    rw_d    = head.rw;
                    addr_d  = head.addr;
                    wdata_d = head.rw ? '0 : head.wdata;
                    state_d = ACCESS;
                end else begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            // ready on the terminal watchdog cycle still completes normally.
            ACCESS: if (ready || tmo) begin
                cs_d    = 1'b0;
                rw_d    = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                rdata_d = (ready && rw_q) ? data_in : '0;
                err_d   = !ready;
                state_d = RESP;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cs_q    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: directed self-checking bench for bus_initiator against a small RAM responder model.
module tb_bus_initiator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_rw = 1'b0, rsp_ready = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, cs, rw, ready;
    logic [31:0] rsp_rdata, data_out, data_in;
    logic [15:0] addr;

    always #5 clk = ~clk;

    bus_initiator #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cs(cs), .rw(rw), .addr(addr), .data_out(data_out), .data_in(data_in), .ready(ready)
    );

    // Responder: sees cs, strobes ready two edges later, then waits for cs low.
    logic        resp_en = 1'b1;
    logic [1:0]  ph = 2'd0;
    logic        r_ready = 1'b0;
    logic [31:0] r_data = '0;
    logic [31:0] mem [0:63];
    assign ready   = r_ready;
    assign data_in = r_data;

    initial for (int i = 0; i < 64; i++) mem[i] = '0;

    always @(posedge clk) begin
        if (!resp_en) begin
            ph      <= 2'd0;
            r_ready <= 1'b0;
        end else begin
            case (ph)
                2'd0: if (cs) ph <= 2'd1;
                2'd1: begin
                    r_ready <= 1'b1;
                    ph      <= 2'd2;
                    if (rw) r_data <= mem[addr[7:2]];
                    else    mem[addr[7:2]] <= data_out;
                end
                2'd2: begin
                    r_ready <= 1'b0;
                    ph      <= 2'd3;
                end
                default: if (!cs) ph <= 2'd0;
            endcase
        end
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge: cs high lengths, cs-low gaps, rises and accepted responses.
    int          hi_q[$];
    logic [32:0] rsp_q[$];
    int          cur_hi = 0, gap = 0, min_gap = 1000, n_rise = 0;
    logic        prev_cs = 1'b0, seen_fall = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            cur_hi    = 0;
            seen_fall = 1'b0;
        end else begin
            if (cs) begin
                if (!prev_cs) begin
                    n_rise++;
                    if (seen_fall && gap < min_gap) min_gap = gap;
                end
                cur_hi++;
                gap = 0;
            end else begin
                if (prev_cs) begin
                    hi_q.push_back(cur_hi);
                    check("rsp_valid_at_cs_fall", {31'd0, rsp_valid}, 32'd1);
                    cur_hi    = 0;
                    seen_fall = 1'b1;
                end
                gap++;
            end
            if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_err, rsp_rdata});
        end
        prev_cs = cs;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic r, input logic [15:0] a, input logic [31:0] d);
        int w = 0;
        while (!req_ready && w < 100) begin
            step(1);
            w++;
        end
        if (w == 100) check("send_req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_rw    = r;
        req_addr  = a;
        req_wdata = d;
        step(1);
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic e, input logic [31:0] d);
        int w = 0;
        logic [32:0] r;
        while (rsp_q.size() == 0 && w < 200) begin
            step(1);
            w++;
        end
        if (rsp_q.size() == 0) begin
            check({tag, "_present"}, 32'(rsp_q.size()), 32'd1);
        end else begin
            r = rsp_q.pop_front();
            check({tag, "_err"}, {31'd0, r[32]}, {31'd0, e});
            check({tag, "_rdata"}, r[31:0], d);
        end
    endtask

    task automatic check_hi(input string tag, input int n, input int len);
        check({tag, "_count"}, 32'(hi_q.size()), 32'(n));
        foreach (hi_q[i]) check({tag, "_len"}, 32'(hi_q[i]), 32'(len));
    endtask

    int r0;

    initial begin
        step(3);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_cs", {31'd0, cs}, 32'd0);
        check("rst_rw", {31'd0, rw}, 32'd0);
        check("rst_addr", {16'd0, addr}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b0;
        step(1);

        // write then read back
        rsp_ready = 1'b1;
        hi_q.delete();
        send(1'b0, 16'h0010, 32'hDEADBEEF);
        check("t1_cs_after_push", {31'd0, cs}, 32'd0);
        step(1);
        check("t1_cs_after_pop", {31'd0, cs}, 32'd1);
        check("t1_addr", {16'd0, addr}, 32'h0010);
        check("t1_data_out", data_out, 32'hDEADBEEF);
        get_rsp("t1_wr", 1'b0, 32'd0);
        send(1'b1, 16'h0010, 32'h0);
        get_rsp("t1_rd", 1'b0, 32'hDEADBEEF);
        step(2);
        check_hi("t1_cs", 2, 3);

        // fill the FIFO with responses stalled
        rsp_ready = 1'b0;
        hi_q.delete();
        r0 = n_rise;
        send(1'b0, 16'h0020, 32'h11111111);
        send(1'b0, 16'h0024, 32'h22222222);
        send(1'b1, 16'h0020, 32'h0);
        send(1'b1, 16'h0024, 32'h0);
        send(1'b1, 16'h0010, 32'h0);
        check("t2_full", {31'd0, req_ready}, 32'd0);
        step(8);
        check("t2_stall_valid", {31'd0, rsp_valid}, 32'd1);
        check("t2_stall_full", {31'd0, req_ready}, 32'd0);
        check("t2_one_on_bus", 32'(n_rise - r0), 32'd1);
        rsp_ready = 1'b1;
        get_rsp("t2_r0", 1'b0, 32'd0);
        get_rsp("t2_r1", 1'b0, 32'd0);
        get_rsp("t2_r2", 1'b0, 32'h11111111);
        get_rsp("t2_r3", 1'b0, 32'h22222222);
        get_rsp("t2_r4", 1'b0, 32'hDEADBEEF);
        step(2);
        check_hi("t2_cs", 5, 3);
        check("t2_min_gap_ge2", {31'd0, min_gap >= 2}, 32'd1);

        // misaligned read, then a normal one
        r0 = n_rise;
        send(1'b1, 16'h0012, 32'h0);
        step(1);
        check("t3_rsp_1cyc", {31'd0, rsp_valid}, 32'd1);
        get_rsp("t3_mis", 1'b1, 32'd0);
        check("t3_no_cs", 32'(n_rise - r0), 32'd0);
        send(1'b1, 16'h0020, 32'h0);
        get_rsp("t3_next", 1'b0, 32'h11111111);

        // silent responder
        resp_en = 1'b0;
        step(2);
        hi_q.delete();
        send(1'b1, 16'h0010, 32'h0);
`ifdef BUS_INITIATOR_TIMEOUT_EN
        get_rsp("t4_tmo", 1'b1, 32'd0);
        check("t4_cs_len", 32'(hi_q.size() > 0 ? hi_q[0] : 0), 32'd16);
`else
        step(40);
        check("t4_cs_stuck", {31'd0, cs}, 32'd1);
        check("t4_no_rsp", {31'd0, rsp_valid}, 32'd0);
`endif

        // reset in the middle of an access with requests queued
        send(1'b1, 16'h0010, 32'h0);
        send(1'b0, 16'h0010, 32'hBAD0BAD0);
        send(1'b0, 16'h0010, 32'h0BADF00D);
        step(1);
        check("t5_cs_before", {31'd0, cs}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_cs", {31'd0, cs}, 32'd0);
        check("t5_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("t5_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step(1);
        reset   = 1'b0;
        resp_en = 1'b1;
        rsp_q.delete();
        r0 = n_rise;
        step(10);
        check("t5_no_rsp", 32'(rsp_q.size()), 32'd0);
        check("t5_no_cs", 32'(n_rise - r0), 32'd0);
        send(1'b1, 16'h0010, 32'h0);
        get_rsp("t5_post", 1'b0, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule
